// File: rtl/lpixs_burst_sram_bridge_pkg.sv
// rtl/lpixs_burst_sram_bridge_pkg.sv - shared types, parcel widths and field offsets for the LPIXS SRAM bridge
package lpixs_burst_sram_bridge_pkg;

    // Burst types carried in the aburst field; encoding 3 is treated as INCR
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    // Fixed-width fields of the request parcel
    localparam int QW_ABURST = 2;
    localparam int QW_ASIZE  = 3;
    localparam int QW_ALEN   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WRESP = 2'd2,
        ST_READ  = 2'd3
    } state_e;

    // Request parcel: {burden, write, alen, asize, aburst, wstrb, wdata, addr}, addr at bit 0
    function automatic int BW_LPIXS_QPARCEL(input int bw_addr, input int bw_data, input int bw_burden);
        return bw_burden + 1 + QW_ALEN + QW_ASIZE + QW_ABURST + bw_data / 8 + bw_data + bw_addr;
    endfunction

    // Response parcel: {burden, rdata}
    function automatic int BW_LPIXS_YPARCEL(input int bw_data, input int bw_burden);
        return bw_burden + bw_data;
    endfunction

    function automatic int qoff_wdata(input int bw_addr);
        return bw_addr;
    endfunction

    function automatic int qoff_wstrb(input int bw_addr, input int bw_data);
        return bw_addr + bw_data;
    endfunction

    function automatic int qoff_aburst(input int bw_addr, input int bw_data);
        return qoff_wstrb(bw_addr, bw_data) + bw_data / 8;
    endfunction

    function automatic int qoff_asize(input int bw_addr, input int bw_data);
        return qoff_aburst(bw_addr, bw_data) + QW_ABURST;
    endfunction

    function automatic int qoff_alen(input int bw_addr, input int bw_data);
        return qoff_asize(bw_addr, bw_data) + QW_ASIZE;
    endfunction

    function automatic int qoff_write(input int bw_addr, input int bw_data);
        return qoff_alen(bw_addr, bw_data) + QW_ALEN;
    endfunction

    function automatic int qoff_burden(input int bw_addr, input int bw_data);
        return qoff_write(bw_addr, bw_data) + 1;
    endfunction

endpackage

// File: rtl/lpixs_sram_rsp_fifo.sv
// rtl/lpixs_sram_rsp_fifo.sv - 2-entry response FIFO carrying {ylast, burden, rdata}
module lpixs_sram_rsp_fifo #(
    parameter int BW = 34
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [BW-1:0] wr_data_i,
    output logic          rd_valid_o,
    input  logic          rd_ready_i,
    output logic [BW-1:0] rd_data_o,
    output logic [1:0]    count_o
);

    logic [BW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic [1:0]    count_d;
    logic          pop;

    assign pop        = rd_valid_o & rd_ready_i;
    assign rd_valid_o = (count_q != 2'd0);
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

    // Occupancy tracks simultaneous push and pop; the producer never pushes when full
    always_comb begin
        count_d = count_q + {1'b0, wr_en_i} - {1'b0, pop};
    end

    // Storage and pointers; head is cleared on reset so the response outputs read zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lpixs_burst_sram_bridge.sv
// rtl/lpixs_burst_sram_bridge.sv - LPIXS burst to single-beat SRAM bridge (WRAP bursts built with LPIXS_SRAM_WRAP_BURST_EN)
module lpixs_burst_sram_bridge
    import lpixs_burst_sram_bridge_pkg::*;
#(
    parameter int BW_ADDR       = 32,
    parameter int BW_DATA       = 32,
    parameter int BW_LPI_BURDEN = 1,
    parameter int BW_SRAM_ADDR  = 12
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic                                                     s_qvalid,
    output logic                                                     s_qready,
    input  logic                                                     s_qlast,
    input  logic [BW_LPIXS_QPARCEL(BW_ADDR, BW_DATA, BW_LPI_BURDEN)-1:0] s_qparcel,
    output logic                                                     s_yvalid,
    input  logic                                                     s_yready,
    output logic                                                     s_ylast,
    output logic [BW_LPIXS_YPARCEL(BW_DATA, BW_LPI_BURDEN)-1:0]        s_yparcel,
    output logic                                                     sram_req,
    output logic                                                     sram_we,
    output logic [BW_SRAM_ADDR-1:0]                                  sram_addr,
    output logic [BW_DATA/8-1:0]                                     sram_be,
    output logic [BW_DATA-1:0]                                       sram_wdata,
    input  logic [BW_DATA-1:0]                                       sram_rdata
);

    localparam int BE          = BW_DATA / 8;
    localparam int LOG2B       = (BE > 1) ? $clog2(BE) : 0;
    localparam int YW          = BW_LPIXS_YPARCEL(BW_DATA, BW_LPI_BURDEN);
    localparam int FW          = YW + 1;
    localparam int OFF_WDATA   = qoff_wdata(BW_ADDR);
    localparam int OFF_WSTRB   = qoff_wstrb(BW_ADDR, BW_DATA);
    localparam int OFF_ABURST  = qoff_aburst(BW_ADDR, BW_DATA);
    localparam int OFF_ASIZE   = qoff_asize(BW_ADDR, BW_DATA);
    localparam int OFF_ALEN    = qoff_alen(BW_ADDR, BW_DATA);
    localparam int OFF_WRITE   = qoff_write(BW_ADDR, BW_DATA);
    localparam int OFF_BURDEN  = qoff_burden(BW_ADDR, BW_DATA);
    localparam logic [2:0]         MAX_ASIZE = 3'(LOG2B);
    localparam logic [BW_ADDR-1:0] ADDR_ONE  = {{(BW_ADDR-1){1'b0}}, 1'b1};

    // Request parcel fields
    logic [BW_ADDR-1:0]       q_addr;
    logic [BW_DATA-1:0]       q_wdata;
    logic [BE-1:0]            q_wstrb;
    logic [1:0]               q_aburst;
    logic [2:0]               q_asize;
    logic [7:0]               q_alen;
    logic                     q_write;
    logic [BW_LPI_BURDEN-1:0] q_burden;
    logic [2:0]               asize_eff;

    assign q_addr    = s_qparcel[0 +: BW_ADDR];
    assign q_wdata   = s_qparcel[OFF_WDATA +: BW_DATA];
    assign q_wstrb   = s_qparcel[OFF_WSTRB +: BE];
    assign q_aburst  = s_qparcel[OFF_ABURST +: QW_ABURST];
    assign q_asize   = s_qparcel[OFF_ASIZE +: QW_ASIZE];
    assign q_alen    = s_qparcel[OFF_ALEN +: QW_ALEN];
    assign q_write   = s_qparcel[OFF_WRITE];
    assign q_burden  = s_qparcel[OFF_BURDEN +: BW_LPI_BURDEN];
    assign asize_eff = (q_asize > MAX_ASIZE) ? MAX_ASIZE : q_asize;

    state_e                   state_q, state_d;
    logic [BW_LPI_BURDEN-1:0] burden_q, burden_d;
    logic [7:0]               alen_q, alen_d;
    logic [2:0]               asize_q, asize_d;
    logic [1:0]               aburst_q, aburst_d;
    logic [BW_ADDR-1:0]       addr_q, addr_d;
    logic [7:0]               beat_q, beat_d;
    logic                     inflight_q;
    logic                     inflight_last_q;

    logic                     rd_issue;
    logic                     rd_issue_last;
    logic                     wresp_push;

    // Response FIFO plumbing
    logic                     fifo_push;
    logic [FW-1:0]            fifo_wdata;
    logic                     fifo_valid;
    logic [FW-1:0]            fifo_rdata;
    logic [1:0]               fifo_count;
    logic                     fifo_pop;
    logic [1:0]               occ_next;

    // Address of the beat being issued: the parcel in IDLE, the generated address afterwards
    logic [BW_ADDR-1:0]       cur_addr;
    logic [2:0]               cur_size;
    logic [1:0]               cur_burst;
    logic [BW_ADDR-1:0]       addr_step;
    logic [BW_ADDR-1:0]       addr_incr;
    logic [BW_ADDR-1:0]       addr_next;

    assign cur_addr  = (state_q == ST_IDLE) ? q_addr    : addr_q;
    assign cur_size  = (state_q == ST_IDLE) ? asize_eff : asize_q;
    assign cur_burst = (state_q == ST_IDLE) ? q_aburst  : aburst_q;

`ifdef LPIXS_SRAM_WRAP_BURST_EN
    logic [7:0]               cur_len;
    logic [BW_ADDR-1:0]       wrap_mask;

    assign cur_len = (state_q == ST_IDLE) ? q_alen : alen_q;
`endif

    // Next beat address: FIXED holds, INCR (and encoding 3) steps, WRAP steps inside its aligned window
    always_comb begin
        addr_step = ADDR_ONE << cur_size;
        addr_incr = cur_addr + addr_step;
        addr_next = addr_incr;
`ifdef LPIXS_SRAM_WRAP_BURST_EN
        wrap_mask = ((ADDR_ONE + BW_ADDR'(cur_len)) << cur_size) - ADDR_ONE;
`endif
        if (cur_burst == BURST_FIXED) begin
            addr_next = cur_addr;
        end
`ifdef LPIXS_SRAM_WRAP_BURST_EN
        else if (cur_burst == BURST_WRAP) begin
            addr_next = (cur_addr & ~wrap_mask) | (addr_incr & wrap_mask);
        end
`endif
    end

    // Reads are throttled so FIFO entries plus the read in flight never exceed two
    assign fifo_pop = fifo_valid & s_yready;
    assign occ_next = fifo_count - {1'b0, fifo_pop} + {1'b0, inflight_q};

    // Burst sequencer: next state, latched burst context and SRAM strobes
    always_comb begin
        state_d       = state_q;
        burden_d      = burden_q;
        alen_d        = alen_q;
        asize_d       = asize_q;
        aburst_d      = aburst_q;
        addr_d        = addr_q;
        beat_d        = beat_q;
        s_qready      = 1'b0;
        sram_req      = 1'b0;
        sram_we       = 1'b0;
        sram_addr     = '0;
        sram_be       = '0;
        sram_wdata    = '0;
        rd_issue      = 1'b0;
        rd_issue_last = 1'b0;
        wresp_push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_qready = ~rst & ~fifo_valid & ~inflight_q;
                if (s_qvalid && s_qready) begin
                    burden_d = q_burden;
                    alen_d   = q_alen;
                    asize_d  = asize_eff;
                    aburst_d = q_aburst;
                    beat_d   = 8'd0;
                    if (q_write) begin
                        sram_req   = 1'b1;
                        sram_we    = 1'b1;
                        sram_addr  = cur_addr[LOG2B +: BW_SRAM_ADDR];
                        sram_be    = q_wstrb;
                        sram_wdata = q_wdata;
                        addr_d     = addr_next;
                        beat_d     = 8'd1;
                        state_d    = (s_qlast || q_alen == 8'd0) ? ST_WRESP : ST_WRITE;
                    end else begin
                        addr_d  = q_addr;
                        state_d = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                s_qready = 1'b1;
                if (s_qvalid) begin
                    sram_req   = 1'b1;
                    sram_we    = 1'b1;
                    sram_addr  = cur_addr[LOG2B +: BW_SRAM_ADDR];
                    sram_be    = q_wstrb;
                    sram_wdata = q_wdata;
                    addr_d     = addr_next;
                    beat_d     = beat_q + 8'd1;
                    if (s_qlast || beat_q == alen_q) begin
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                wresp_push = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_READ: begin
                if (occ_next < 2'd2) begin
                    sram_req      = 1'b1;
                    sram_addr     = cur_addr[LOG2B +: BW_SRAM_ADDR];
                    rd_issue      = 1'b1;
                    rd_issue_last = (beat_q == alen_q);
                    addr_d        = addr_next;
                    beat_d        = beat_q + 8'd1;
                    if (beat_q == alen_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers and the one-deep read pipeline marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            burden_q        <= '0;
            alen_q          <= 8'd0;
            asize_q         <= 3'd0;
            aburst_q        <= 2'd0;
            addr_q          <= '0;
            beat_q          <= 8'd0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            burden_q        <= burden_d;
            alen_q          <= alen_d;
            asize_q         <= asize_d;
            aburst_q        <= aburst_d;
            addr_q          <= addr_d;
            beat_q          <= beat_d;
            inflight_q      <= rd_issue;
            inflight_last_q <= rd_issue_last;
        end
    end

    // Read capture and write response never coincide, so a simple mux feeds the FIFO
    assign fifo_push  = inflight_q | wresp_push;
    assign fifo_wdata = inflight_q ? {inflight_last_q, burden_q, sram_rdata}
                                   : {1'b1, burden_q, {BW_DATA{1'b0}}};

    lpixs_sram_rsp_fifo #(
        .BW (FW)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (fifo_push),
        .wr_data_i  (fifo_wdata),
        .rd_valid_o (fifo_valid),
        .rd_ready_i (s_yready),
        .rd_data_o  (fifo_rdata),
        .count_o    (fifo_count)
    );

    assign s_yvalid  = fifo_valid;
    assign s_ylast   = fifo_rdata[FW-1];
    assign s_yparcel = fifo_rdata[YW-1:0];

endmodule

// File: tb/tb_lpixs_burst_sram_bridge.sv
// tb/tb_lpixs_burst_sram_bridge.sv - scoreboard bench for lpixs_burst_sram_bridge
module tb_lpixs_burst_sram_bridge;

    localparam int QW = lpixs_burst_sram_bridge_pkg::BW_LPIXS_QPARCEL(32, 32, 1);
    localparam int YW = lpixs_burst_sram_bridge_pkg::BW_LPIXS_YPARCEL(32, 1);

    logic          clk;
    logic          rst;
    logic          s_qvalid;
    logic          s_qready;
    logic          s_qlast;
    logic [QW-1:0] s_qparcel;
    logic          s_yvalid;
    logic          s_yready;
    logic          s_ylast;
    logic [YW-1:0] s_yparcel;
    logic          sram_req;
    logic          sram_we;
    logic [11:0]   sram_addr;
    logic [3:0]    sram_be;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    lpixs_burst_sram_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .s_qvalid   (s_qvalid),
        .s_qready   (s_qready),
        .s_qlast    (s_qlast),
        .s_qparcel  (s_qparcel),
        .s_yvalid   (s_yvalid),
        .s_yready   (s_yready),
        .s_ylast    (s_ylast),
        .s_yparcel  (s_yparcel),
        .sram_req   (sram_req),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_be    (sram_be),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    typedef struct packed {
        logic        last;
        logic        burden;
        logic [31:0] data;
    } rsp_t;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    int   checks = 0;
    int   errors = 0;
    int   outst = 0;
    bit   timed_out = 1'b0;
    bit   tmo_counted = 1'b0;
    bit   done = 1'b0;

    function automatic logic [31:0] pat(input int w);
        return 32'hD000_0000 | w;
    endfunction

    // SRAM model: word memory preloaded with pat(), one-cycle read latency
    logic [31:0] mem [0:4095];
    bit          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
            loaded <= 1'b1;
        end else if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Monitor: reset checks, SRAM access and response scoreboards, final summary
    always @(negedge clk) begin
        acc_t a;
        rsp_t r;
        if (rst) begin
            chk("rst_ctrl", {59'd0, s_qready, s_yvalid, s_ylast, sram_req, sram_we}, 64'd0);
            chk("rst_yparcel", {31'd0, s_yparcel}, 64'd0);
            chk("rst_sram", {16'd0, sram_addr, sram_be, sram_wdata}, 64'd0);
            exp_acc.delete();
            exp_rsp.delete();
            outst = 0;
        end else begin
            if (s_yvalid && s_yready) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", {31'd0, s_yparcel}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_last", {63'd0, s_ylast}, {63'd0, r.last});
                    chk("rsp_burden", {63'd0, s_yparcel[32]}, {63'd0, r.burden});
                    chk("rsp_data", {32'd0, s_yparcel[31:0]}, {32'd0, r.data});
                end
                if (outst > 0) outst--;
            end
            if (sram_req) begin
                if (exp_acc.size() == 0) begin
                    chk("sram_unexpected", {51'd0, sram_we, sram_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    a = exp_acc.pop_front();
                    chk("sram_we", {63'd0, sram_we}, {63'd0, a.we});
                    chk("sram_addr", {52'd0, sram_addr}, {52'd0, a.addr});
                    if (a.we) begin
                        chk("sram_be", {60'd0, sram_be}, {60'd0, a.be});
                        chk("sram_wdata", {32'd0, sram_wdata}, {32'd0, a.wdata});
                    end
                end
                if (!sram_we) begin
                    outst++;
                    chk("outstanding_le2", {63'd0, outst > 2}, 64'd0);
                end
            end
            if (timed_out && !tmo_counted) begin
                tmo_counted = 1'b1;
                checks++;
                errors++;
                $display("FAIL timeout act=expired exp=completed");
            end
            if (done) begin
                chk("acc_queue_empty", 64'(exp_acc.size()), 64'd0);
                chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    task automatic exp_rd(input logic b, input int w, input logic last);
        exp_acc.push_back('{we: 1'b0, addr: 12'(w), be: 4'h0, wdata: 32'h0});
        exp_rsp.push_back('{last: last, burden: b, data: pat(w)});
    endtask

    task automatic exp_rd_data(input logic b, input int w, input logic [31:0] d, input logic last);
        exp_acc.push_back('{we: 1'b0, addr: 12'(w), be: 4'h0, wdata: 32'h0});
        exp_rsp.push_back('{last: last, burden: b, data: d});
    endtask

    task automatic exp_wr(input int w, input logic [3:0] be, input logic [31:0] d);
        exp_acc.push_back('{we: 1'b1, addr: 12'(w), be: be, wdata: d});
    endtask

    task automatic exp_wresp(input logic b);
        exp_rsp.push_back('{last: 1'b1, burden: b, data: 32'h0});
    endtask

    task automatic send(input logic b, input logic w, input logic [7:0] alen, input logic [2:0] asz,
                        input logic [1:0] ab, input logic [3:0] strb, input logic [31:0] wd,
                        input logic [31:0] ad, input logic last);
        int n;
        s_qparcel = {b, w, alen, asz, ab, strb, wd, ad};
        s_qlast   = last;
        s_qvalid  = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (s_qready) break;
            n++;
            if (n > 200) begin
                timed_out = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_qvalid  = 1'b0;
        s_qlast   = 1'b0;
        s_qparcel = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_acc.size() != 0 || exp_rsp.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timed_out = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int wl[4];
        rst       = 1'b1;
        s_qvalid  = 1'b0;
        s_qlast   = 1'b0;
        s_qparcel = '0;
        s_yready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single write to 0x10 -> word 4, one response with burden 1
        exp_wr(4, 4'hF, 32'hA5A5_A5A5);
        exp_wresp(1'b1);
        send(1'b1, 1'b1, 8'd0, 3'd2, 2'd1, 4'hF, 32'hA5A5_A5A5, 32'h10, 1'b1);
        wait_idle();

        // INCR read of four words from 0x20
        for (int i = 0; i < 4; i++) exp_rd(1'b0, 8 + i, i == 3);
        send(1'b0, 1'b0, 8'd3, 3'd2, 2'd1, 4'h0, 32'h0, 32'h20, 1'b0);
        wait_idle();

        // WRAP read from 0x38
`ifdef LPIXS_SRAM_WRAP_BURST_EN
        wl = '{14, 15, 12, 13};
`else
        wl = '{14, 15, 16, 17};
`endif
        for (int i = 0; i < 4; i++) exp_rd(1'b1, wl[i], i == 3);
        send(1'b1, 1'b0, 8'd3, 3'd2, 2'd2, 4'h0, 32'h0, 32'h38, 1'b0);
        wait_idle();

        // Eight-beat read with s_yready toggling
        for (int i = 0; i < 8; i++) exp_rd(1'b0, 64 + i, i == 7);
        fork
            send(1'b0, 1'b0, 8'd7, 3'd2, 2'd1, 4'h0, 32'h0, 32'h100, 1'b0);
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    s_yready = ~s_yready;
                end
            end
        join
        s_yready = 1'b1;
        wait_idle();

        // FIXED write of three beats to 0x40; later beats carry a bogus addr that must be ignored
        exp_wr(16, 4'hF, 32'h1111_1111);
        exp_wr(16, 4'hF, 32'h2222_2222);
        exp_wr(16, 4'h3, 32'h3333_3333);
        exp_wresp(1'b0);
        send(1'b0, 1'b1, 8'd2, 3'd2, 2'd0, 4'hF, 32'h1111_1111, 32'h40, 1'b0);
        send(1'b0, 1'b1, 8'd2, 3'd2, 2'd0, 4'hF, 32'h2222_2222, 32'hFFF0, 1'b0);
        send(1'b0, 1'b1, 8'd2, 3'd2, 2'd0, 4'h3, 32'h3333_3333, 32'hFFF0, 1'b1);
        wait_idle();
        exp_rd_data(1'b1, 16, 32'h2222_3333, 1'b1);
        send(1'b1, 1'b0, 8'd0, 3'd2, 2'd1, 4'h0, 32'h0, 32'h40, 1'b0);
        wait_idle();

        // INCR write alen=3 ended early by s_qlast on beat 1
        exp_wr(32, 4'hF, 32'hCAFE_0000);
        exp_wr(33, 4'hF, 32'hCAFE_0001);
        exp_wresp(1'b1);
        send(1'b1, 1'b1, 8'd3, 3'd2, 2'd1, 4'hF, 32'hCAFE_0000, 32'h80, 1'b0);
        send(1'b1, 1'b1, 8'd3, 3'd2, 2'd1, 4'hF, 32'hCAFE_0001, 32'h0, 1'b1);
        wait_idle();
        exp_rd_data(1'b0, 32, 32'hCAFE_0000, 1'b0);
        exp_rd_data(1'b0, 33, 32'hCAFE_0001, 1'b0);
        exp_rd(1'b0, 34, 1'b1);
        send(1'b0, 1'b0, 8'd2, 3'd2, 2'd1, 4'h0, 32'h0, 32'h80, 1'b0);
        wait_idle();

        // asize=3 clamps to 4-byte steps; then read back the first write
        exp_rd(1'b1, 128, 1'b0);
        exp_rd(1'b1, 129, 1'b1);
        send(1'b1, 1'b0, 8'd1, 3'd3, 2'd1, 4'h0, 32'h0, 32'h200, 1'b0);
        wait_idle();
        exp_rd_data(1'b0, 4, 32'hA5A5_A5A5, 1'b1);
        send(1'b0, 1'b0, 8'd0, 3'd2, 2'd1, 4'h0, 32'h0, 32'h10, 1'b0);
        wait_idle();

        // Reset in the middle of a stalled 16-beat read, then a clean request
        s_yready = 1'b0;
        for (int i = 0; i < 16; i++) exp_rd(1'b1, 192 + i, i == 15);
        send(1'b1, 1'b0, 8'd15, 3'd2, 2'd1, 4'h0, 32'h0, 32'h300, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        s_yready = 1'b1;
        @(posedge clk);
        #1;
        exp_rd(1'b1, 8, 1'b1);
        send(1'b1, 1'b0, 8'd0, 3'd2, 2'd1, 4'h0, 32'h0, 32'h20, 1'b0);
        wait_idle();

        done = 1'b1;
    end

endmodule
